debug_scanner: RTL
==================

DEBUG_SCANNER -- requirements
Module: debug_scanner

Interface
REQ-001 SHALL have parameter SCAN_FIRST, default 0, first debug address swept.
REQ-002 SHALL have parameter SCAN_LAST, default 127, last debug address swept (inclusive); SCAN_FIRST <= SCAN_LAST <= 127.
REQ-003 SHALL have parameter SETTLE, default 1, cycles (1..15) between debug_addr change and sampling debug_data.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk and rst.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port hold, input, 1 bit, keep the CPU frozen in debug mode.
REQ-008 SHALL have port step_req, input, 1 bit, request one CPU single step.
REQ-009 SHALL have port start, input, 1 bit, request one address sweep.
REQ-010 SHALL have port debug_data, input, 32 bits, CPU debug read data.
REQ-011 SHALL have port snap_ready, input, 1 bit, sink accepts snapshot word.
REQ-012 SHALL have port debug_en, output, 1 bit, CPU debug mode.
REQ-013 SHALL have port debug_step, output, 1 bit, single-cycle step pulse.
REQ-014 SHALL have port debug_addr, output, 7 bits, CPU debug read address.
REQ-015 SHALL have ports snap_valid (output, 1), snap_addr (output, 7), snap_data (output, 32): captured word stream.
REQ-016 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse), scan_sum (output, 32).

Function
REQ-017 SHALL implement FSM states IDLE, STEP, SETTLE, SAMPLE, OUT, DONE; all outputs registered.
REQ-018 SHALL drive debug_en = 1 whenever hold = 1 or state != IDLE.
REQ-019 SHALL, in IDLE with step_req = 1, enter STEP and assert debug_step for exactly one cycle, then return to IDLE.
REQ-020 SHALL, in IDLE with start = 1 (no step_req), load debug_addr = SCAN_FIRST, assert busy, enter SETTLE the next cycle.
REQ-021 SHALL, when start and step_req coincide in IDLE, perform the step first, then the sweep with no idle cycle between.
REQ-022 SHALL remain in SETTLE for SETTLE cycles, then SAMPLE latches debug_data and debug_addr into snap_data/snap_addr.
REQ-023 SHALL assert snap_valid in OUT, holding snap_addr/snap_data stable until snap_valid & snap_ready.
REQ-024 SHALL, on handshake with debug_addr < SCAN_LAST, increment debug_addr and re-enter SETTLE; with debug_addr == SCAN_LAST, enter DONE.
REQ-025 SHALL pulse done for one cycle in DONE, clear busy, return to IDLE.
REQ-026 SHALL ignore start while busy; a step_req while busy SHALL set one sticky pending flag executed as a step on return to IDLE (further requests not queued).
REQ-027 SHALL keep sweeping if hold falls mid-sweep; debug_en stays 1 until DONE.
REQ-028 SHALL yield first snap_valid at cycle 2+SETTLE after start sampled at cycle 0 (snap_ready held high).

Reset
REQ-029 SHALL, on rst = 0 at any time including mid-sweep, force IDLE and clear debug_en, debug_step, debug_addr, snap_valid, snap_addr, snap_data, busy, done, scan_sum, pending flag to 0.

Configuration
REQ-030 SHALL, with DEBUG_SCAN_SUM_EN defined, accumulate the modulo-2^32 sum of every handshaken snap_data, cleared at sweep start, scan_sum updated in the DONE cycle and held until next sweep.
REQ-031 SHALL, without DEBUG_SCAN_SUM_EN, tie scan_sum to 0 and contain no accumulator logic.

Structure
REQ-032 SHALL place state enum, DBG_ADDR_W = 7, DBG_DATA_W = 32 in shared package dbg_pkg.
REQ-033 SHALL place the accumulator in sub-module dbg_sum_acc, instantiated only under DEBUG_SCAN_SUM_EN.

Verification
REQ-034 SHALL check: SCAN_FIRST=1, SCAN_LAST=3, debug_data = addr*16, snap_ready=1, start -> words (1,0x10),(2,0x20),(3,0x30), done once, scan_sum=0x60 (macro on) or 0 (off).
REQ-035 SHALL check: snap_ready low 5 cycles during word 2 -> snap_valid held, snap_data=0x20 stable, debug_addr unchanged.
REQ-036 SHALL check: hold=1, step_req pulse -> debug_step high exactly 1 cycle, debug_en=1 throughout, busy=0.
REQ-037 SHALL check: start and step_req same cycle -> debug_step pulse, then debug_addr=SCAN_FIRST next cycle; start during sweep ignored.
REQ-038 SHALL check: rst low during word 2 of sweep -> all outputs 0 asynchronously, new start after release sweeps from SCAN_FIRST.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared widths and FSM state encoding for the debug scanner slice.
package dbg_pkg;
  localparam int unsigned DBG_ADDR_W = 7;
  localparam int unsigned DBG_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_SAMPLE,
    ST_OUT,
    ST_DONE
  } dbg_state_e;
endpackage

// File: rtl/dbg_sum_acc.sv
// Modulo-2^32 accumulator of accepted snapshot words; the published sum is
// refreshed together with the final word of a sweep.
module dbg_sum_acc
  import dbg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  add_en,
  input  logic                  last,
  input  logic [DBG_DATA_W-1:0] add_data,
  output logic [DBG_DATA_W-1:0] sum
);
  logic [DBG_DATA_W-1:0] acc;
  logic [DBG_DATA_W-1:0] acc_next;

  assign acc_next = acc + add_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      sum <= '0;
    end else if (clr) begin
      acc <= '0;
      sum <= '0;
    end else if (add_en) begin
      acc <= acc_next;
      if (last) sum <= acc_next;
    end
  end
endmodule

// File: rtl/debug_scanner.sv
// Freezes the CPU in debug mode, issues single steps and sweeps debug
// addresses into a snapshot stream. DEBUG_SCAN_SUM_EN adds a sweep checksum.
module debug_scanner
  import dbg_pkg::*;
#(
  parameter int unsigned SCAN_FIRST = 0,
  parameter int unsigned SCAN_LAST  = 127,
  parameter int unsigned SETTLE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  step_req,
  input  logic                  start,
  input  logic [DBG_DATA_W-1:0] debug_data,
  input  logic                  snap_ready,
  output logic                  debug_en,
  output logic                  debug_step,
  output logic [DBG_ADDR_W-1:0] debug_addr,
  output logic                  snap_valid,
  output logic [DBG_ADDR_W-1:0] snap_addr,
  output logic [DBG_DATA_W-1:0] snap_data,
  output logic                  busy,
  output logic                  done,
  output logic [DBG_DATA_W-1:0] scan_sum
);
  localparam logic [DBG_ADDR_W-1:0] FIRST_ADDR  = DBG_ADDR_W'(SCAN_FIRST);
  localparam logic [DBG_ADDR_W-1:0] LAST_ADDR   = DBG_ADDR_W'(SCAN_LAST);
  localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE - 1);

  dbg_state_e state;
  logic [3:0] settle_cnt;
  logic       pending;
  logic       step_then_scan;
  logic       sweep_go;

  assign sweep_go = ((state == ST_IDLE) && start && !step_req && !pending) ||
                    ((state == ST_STEP) && step_then_scan);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      settle_cnt     <= '0;
      pending        <= 1'b0;
      step_then_scan <= 1'b0;
      debug_en       <= 1'b0;
      debug_step     <= 1'b0;
      debug_addr     <= '0;
      snap_valid     <= 1'b0;
      snap_addr      <= '0;
      snap_data      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      debug_step <= 1'b0;
      done       <= 1'b0;
      debug_en   <= 1'b1;
      if (busy && step_req) pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (step_req || pending) begin
            state          <= ST_STEP;
            debug_step     <= 1'b1;
            pending        <= 1'b0;
            step_then_scan <= start;
          end else if (!start) begin
            debug_en <= hold;
          end
        end
        ST_STEP: begin
          step_then_scan <= 1'b0;
          if (!step_then_scan) begin
            state    <= ST_IDLE;
            debug_en <= hold;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= ST_SAMPLE;
          else settle_cnt <= settle_cnt + 4'd1;
        end
        ST_SAMPLE: begin
          snap_data  <= debug_data;
          snap_addr  <= debug_addr;
          snap_valid <= 1'b1;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
            if (debug_addr == LAST_ADDR) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              debug_addr <= debug_addr + 7'd1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          busy     <= 1'b0;
          state    <= ST_IDLE;
          debug_en <= hold;
        end
        default: state <= ST_IDLE;
      endcase

      // Sweep launch overrides the case so a step can chain straight into it.
      if (sweep_go) begin
        state      <= ST_SETTLE;
        debug_addr <= FIRST_ADDR;
        settle_cnt <= '0;
        busy       <= 1'b1;
      end
    end
  end

`ifdef DEBUG_SCAN_SUM_EN
  logic word_accept;
  logic word_last;

  assign word_accept = (state == ST_OUT) && snap_valid && snap_ready;
  assign word_last   = (debug_addr == LAST_ADDR);

  dbg_sum_acc u_sum_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (sweep_go),
    .add_en   (word_accept),
    .last     (word_last),
    .add_data (snap_data),
    .sum      (scan_sum)
  );
`else
  assign scan_sum = '0;
`endif
endmodule
